// File: rtl/sweep_checker_pkg.sv
// Shared types and width helpers for the sweep checker and its per-channel
// squared-error accumulators.
package sweep_checker_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DRAIN,
      DONE
   } state_t;

   localparam int SAMP_W = 32;

   // Difference of two WIDTH-bit signed values needs one extra bit.
   function automatic int diff_width(input int width);
      return width + 1;
   endfunction

   function automatic int sq_width(input int width);
      return 2 * width + 2;
   endfunction

endpackage

// File: rtl/sweep_checker_sq_err_acc.sv
// One channel of error checking: diff = expct - out, square it, and add it into
// a saturating accumulator with a sticky saturation flag.
module sq_err_acc
   import sweep_checker_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ACC_W = 40
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] out_val,
   input  logic signed [WIDTH-1:0] expct_val,
   output logic        [ACC_W-1:0] acc,
   output logic                    sat
);

   localparam int DW    = diff_width(WIDTH);
   localparam int SW    = sq_width(WIDTH);
   localparam int SUM_W = ((ACC_W > SW) ? ACC_W : SW) + 1;

   logic signed [DW-1:0]    diff;
   logic signed [SW-1:0]    prod;
   logic        [SUM_W-1:0] sum;
   logic                    over;

   // The sum is one bit wider than both terms, so any overflow is visible.
   always_comb begin
      diff = DW'(expct_val) - DW'(out_val);
      prod = diff * diff;
      sum  = SUM_W'(acc) + SUM_W'($unsigned(prod));
      over = sum > SUM_W'({ACC_W{1'b1}});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         sat <= 1'b0;
      end else if (clr) begin
         acc <= '0;
         sat <= 1'b0;
      end else if (en) begin
         if (over) begin
            acc <= '1;
            sat <= 1'b1;
         end else begin
            acc <= sum[ACC_W-1:0];
         end
      end
   end

endmodule

// File: rtl/sweep_checker.sv
// Sweeps a stimulus ramp or triangle through an emulated DUT and golden model,
// accumulating per-channel squared error once the pipeline latency has elapsed.
module sweep_checker
   import sweep_checker_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter int               N_CH      = 2,
   parameter int               START     = -4,
   parameter int               STOP      = 4,
   parameter int               STEP      = 1,
   parameter int               PIPE_LAT  = 2,
   parameter int               ACC_W     = 40,
   parameter logic [ACC_W-1:0] ERR_LIMIT = '0
) (
   input  logic                     emu_clk,
   input  logic                     emu_rst_n,
   input  logic                     adv,
   input  logic                     start,
   input  logic                     mode,
   output logic signed [WIDTH-1:0]  stim,
   input  logic [N_CH*WIDTH-1:0]    out_ch,
   input  logic [N_CH*WIDTH-1:0]    expct_ch,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [SAMP_W-1:0]        n_samp,
   output logic [N_CH*ACC_W-1:0]    acc,
   output logic [N_CH-1:0]          sat
);

   localparam int EW    = WIDTH + 1;
   localparam int CNT_W = $clog2(PIPE_LAT + 1);

   localparam logic signed [EW-1:0]    START_E    = EW'(START);
   localparam logic signed [EW-1:0]    STOP_E     = EW'(STOP);
   localparam logic signed [EW-1:0]    STEP_E     = EW'(STEP);
   localparam logic signed [WIDTH-1:0] START_W    = WIDTH'(START);
   localparam logic [CNT_W-1:0]        DRAIN_LAST = CNT_W'(PIPE_LAT - 1);

   typedef logic [PIPE_LAT-1:0] pipe_t;

   state_t                 state;
   state_t                 state_next;
   logic signed [EW-1:0]   stim_e;
   logic signed [EW-1:0]   up_next;
   logic signed [EW-1:0]   dn_next;
   logic                   last_issue;
   logic                   turn_down;
   logic                   accept;
   logic                   issue;
   logic                   dir_down;
   logic                   mode_r;
   pipe_t                  vpipe;
   logic [CNT_W-1:0]       drain_cnt;
   logic                   sample;
   logic                   acc_ok;

   // Next-value decisions use one extra bit so stepping past STOP never wraps.
   always_comb begin
      stim_e     = EW'(stim);
      up_next    = stim_e + STEP_E;
      dn_next    = stim_e - STEP_E;
      turn_down  = 1'b0;
      last_issue = 1'b0;
      if (dir_down) begin
         last_issue = dn_next < START_E;
      end else if (up_next > STOP_E) begin
         if (mode_r && !(dn_next < START_E)) begin
            turn_down = 1'b1;
         end else begin
            last_issue = 1'b1;
         end
      end
   end

   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      issue      = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = SWEEP;
            end
         end
         SWEEP: begin
            if (adv) begin
               issue = 1'b1;
               if (last_issue) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (adv && (drain_cnt == DRAIN_LAST)) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
      busy = (state == SWEEP) || (state == DRAIN);
      done = (state == DONE);
   end

   assign sample = adv && vpipe[PIPE_LAT-1];

   // Everything here only moves on adv; a start restarts from a clean slate.
   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         stim      <= START_W;
         dir_down  <= 1'b0;
         mode_r    <= 1'b0;
         vpipe     <= '0;
         drain_cnt <= '0;
         n_samp    <= '0;
      end else if (accept) begin
         stim      <= START_W;
         dir_down  <= 1'b0;
         mode_r    <= mode;
         vpipe     <= '0;
         drain_cnt <= '0;
         n_samp    <= '0;
      end else if (adv && busy) begin
         vpipe <= pipe_t'({vpipe, issue});
         if (sample) begin
            n_samp <= n_samp + SAMP_W'(1);
         end
         if (issue && !last_issue) begin
            if (turn_down || dir_down) begin
               stim <= dn_next[WIDTH-1:0];
            end else begin
               stim <= up_next[WIDTH-1:0];
            end
            if (turn_down) begin
               dir_down <= 1'b1;
            end
         end
         if (state == DRAIN) begin
            drain_cnt <= drain_cnt + CNT_W'(1);
         end
      end
   end

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      sq_err_acc #(
         .WIDTH (WIDTH),
         .ACC_W (ACC_W)
      ) u_acc (
         .clk       (emu_clk),
         .rst_n     (emu_rst_n),
         .clr       (accept),
         .en        (sample),
         .out_val   (out_ch[ch*WIDTH +: WIDTH]),
         .expct_val (expct_ch[ch*WIDTH +: WIDTH]),
         .acc       (acc[ch*ACC_W +: ACC_W]),
         .sat       (sat[ch])
      );
   end

   always_comb begin
      acc_ok = 1'b1;
      for (int ch = 0; ch < N_CH; ch++) begin
         if (acc[ch*ACC_W +: ACC_W] > ERR_LIMIT) begin
            acc_ok = 1'b0;
         end
      end
      pass = done && (n_samp != '0) && acc_ok && (sat == '0);
   end

endmodule

// File: tb/tb_sweep_checker.sv
// Directed bench for sweep_checker: ramp, triangle, stalled, reset and saturating
// sweeps against an echoing golden model with programmable per-channel offsets.
module tb_sweep_checker;

   logic               emu_clk = 1'b0;
   logic               emu_rst_n;
   logic               adv;
   logic               start;
   logic               mode;
   logic signed [15:0] err0;
   logic signed [15:0] err1;
   logic signed [15:0] d1;
   logic signed [15:0] d2;
   logic [31:0]        out_ch;
   logic [31:0]        expct_ch;

   logic signed [15:0] stim_main, stim_l80, stim_l81, stim_sat;
   logic               busy_main, busy_l80, busy_l81, busy_sat;
   logic               done_main, done_l80, done_l81, done_sat;
   logic               pass_main, pass_l80, pass_l81, pass_sat;
   logic [31:0]        n_samp_main, n_samp_l80, n_samp_l81, n_samp_sat;
   logic [79:0]        acc_main, acc_l80, acc_l81;
   logic [15:0]        acc_sat;
   logic [1:0]         sat_main, sat_l80, sat_l81, sat_sat;

   int n_assert;
   int n_fail;
   int cyc;

   always #5 emu_clk = ~emu_clk;

   // DUT and golden both see the stimulus two advanced cycles late.
   always @(posedge emu_clk) begin
      if (adv) begin
         d1 <= stim_main;
         d2 <= d1;
      end
   end

   assign expct_ch = {d2, d2};
   assign out_ch   = {d2 + err1, d2 + err0};

   sweep_checker dut_main (
      .emu_clk (emu_clk), .emu_rst_n (emu_rst_n), .adv (adv), .start (start),
      .mode (mode), .stim (stim_main), .out_ch (out_ch), .expct_ch (expct_ch),
      .busy (busy_main), .done (done_main), .pass (pass_main),
      .n_samp (n_samp_main), .acc (acc_main), .sat (sat_main)
   );

   sweep_checker #(.ERR_LIMIT (40'd80)) dut_l80 (
      .emu_clk (emu_clk), .emu_rst_n (emu_rst_n), .adv (adv), .start (start),
      .mode (mode), .stim (stim_l80), .out_ch (out_ch), .expct_ch (expct_ch),
      .busy (busy_l80), .done (done_l80), .pass (pass_l80),
      .n_samp (n_samp_l80), .acc (acc_l80), .sat (sat_l80)
   );

   sweep_checker #(.ERR_LIMIT (40'd81)) dut_l81 (
      .emu_clk (emu_clk), .emu_rst_n (emu_rst_n), .adv (adv), .start (start),
      .mode (mode), .stim (stim_l81), .out_ch (out_ch), .expct_ch (expct_ch),
      .busy (busy_l81), .done (done_l81), .pass (pass_l81),
      .n_samp (n_samp_l81), .acc (acc_l81), .sat (sat_l81)
   );

   sweep_checker #(.ACC_W (8)) dut_sat (
      .emu_clk (emu_clk), .emu_rst_n (emu_rst_n), .adv (adv), .start (start),
      .mode (mode), .stim (stim_sat), .out_ch (out_ch), .expct_ch (expct_ch),
      .busy (busy_sat), .done (done_sat), .pass (pass_sat),
      .n_samp (n_samp_sat), .acc (acc_sat), .sat (sat_sat)
   );

   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      n_assert++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic logic signed [63:0] expStim(input logic m, input int i);
      if (!m || i <= 8) return 64'(-4 + i);
      return 64'(12 - i);
   endfunction

   // Cycle k is the k-th cycle after the start edge; outputs are sampled mid-cycle.
   task automatic applyStimulus(input logic m, input bit alt, input int n_issue,
                                output int done_cycle);
      int issued;
      @(negedge emu_clk);
      mode  = m;
      start = 1'b1;
      adv   = alt ? 1'b0 : 1'b1;
      @(negedge emu_clk);
      start = 1'b0;
      checkOutput("start_busy", busy_main, 1);
      checkOutput("start_done", done_main, 0);
      checkOutput("start_nsamp", n_samp_main, 0);
      checkOutput("start_acc", acc_main, 0);
      issued     = 0;
      done_cycle = -1;
      for (int k = 1; k <= 200 && done_cycle < 0; k++) begin
         if (k > 1) @(negedge emu_clk);
         adv = alt ? (k % 2 == 1) : 1'b1;
         if (done_main) begin
            done_cycle = k;
         end else if (adv && issued < n_issue) begin
            checkOutput($sformatf("stim_%0d", issued), stim_main, expStim(m, issued));
            issued++;
         end
      end
      adv = 1'b1;
      checkOutput("done_seen", done_main, 1);
      checkOutput("issue_count", issued, n_issue);
      checkOutput("idle_busy", busy_main, 0);
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      emu_rst_n = 1'b0;
      adv       = 1'b1;
      start     = 1'b0;
      mode      = 1'b0;
      err0      = '0;
      err1      = '0;
      repeat (2) @(negedge emu_clk);
      checkOutput("rst_stim", stim_main, -4);
      checkOutput("rst_busy", busy_main, 0);
      checkOutput("rst_done", done_main, 0);
      checkOutput("rst_pass", pass_main, 0);
      checkOutput("rst_nsamp", n_samp_main, 0);
      checkOutput("rst_acc", acc_main, 0);
      checkOutput("rst_sat", sat_main, 0);
      emu_rst_n = 1'b1;

      $display("[TB] ramp with exact golden match");
      applyStimulus(1'b0, 1'b0, 9, cyc);
      checkOutput("ramp_latency", cyc, 12);
      checkOutput("ramp_nsamp", n_samp_main, 9);
      checkOutput("ramp_acc", acc_main, 0);
      checkOutput("ramp_pass", pass_main, 1);
      checkOutput("ramp_hold", stim_main, 4);
      checkOutput("ramp_sat", sat_main, 0);

      $display("[TB] ramp with channel 1 offset by 3");
      err1 = 16'sd3;
      applyStimulus(1'b0, 1'b0, 9, cyc);
      checkOutput("off_acc0", acc_main[39:0], 0);
      checkOutput("off_acc1", acc_main[79:40], 81);
      checkOutput("off_pass_lim0", pass_main, 0);
      checkOutput("off_pass_lim80", pass_l80, 0);
      checkOutput("off_pass_lim81", pass_l81, 1);
      checkOutput("off_acc1_lim81", acc_l81[79:40], 81);
      err1 = '0;

      $display("[TB] triangle sweep");
      applyStimulus(1'b1, 1'b0, 17, cyc);
      checkOutput("tri_latency", cyc, 20);
      checkOutput("tri_nsamp", n_samp_main, 17);
      checkOutput("tri_hold", stim_main, -4);
      checkOutput("tri_pass", pass_main, 1);

      $display("[TB] ramp with adv alternating");
      applyStimulus(1'b0, 1'b1, 9, cyc);
      checkOutput("alt_latency", cyc, 22);
      checkOutput("alt_nsamp", n_samp_main, 9);
      checkOutput("alt_acc", acc_main, 0);
      checkOutput("alt_pass", pass_main, 1);

      $display("[TB] reset before the fifth sample");
      err1 = 16'sd3;
      @(negedge emu_clk);
      mode  = 1'b0;
      start = 1'b1;
      @(negedge emu_clk);
      start = 1'b0;
      repeat (6) @(negedge emu_clk);
      checkOutput("mid_nsamp", n_samp_main, 4);
      checkOutput("mid_acc1", acc_main[79:40], 36);
      emu_rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_stim", stim_main, -4);
      checkOutput("mid_rst_busy", busy_main, 0);
      checkOutput("mid_rst_done", done_main, 0);
      checkOutput("mid_rst_pass", pass_main, 0);
      checkOutput("mid_rst_nsamp", n_samp_main, 0);
      checkOutput("mid_rst_acc", acc_main, 0);
      checkOutput("mid_rst_sat", sat_main, 0);
      @(negedge emu_clk);
      emu_rst_n = 1'b1;
      err1      = '0;
      applyStimulus(1'b0, 1'b0, 9, cyc);
      checkOutput("rerun_latency", cyc, 12);
      checkOutput("rerun_nsamp", n_samp_main, 9);
      checkOutput("rerun_acc", acc_main, 0);
      checkOutput("rerun_pass", pass_main, 1);

      $display("[TB] channel 0 offset by 6 into an 8-bit accumulator");
      err0 = 16'sd6;
      applyStimulus(1'b0, 1'b0, 9, cyc);
      checkOutput("sat_acc0", acc_sat[7:0], 255);
      checkOutput("sat_acc1", acc_sat[15:8], 0);
      checkOutput("sat_flags", sat_sat, 1);
      checkOutput("sat_pass", pass_sat, 0);
      checkOutput("wide_acc0", acc_main[39:0], 324);
      checkOutput("wide_sat", sat_main, 0);
      err0 = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
